uart_rx_os16: RTL
=================

// Module: uart_rx_os16
// PURPOSE
//  Serial receiver fed by the clkdiv baud generator: consumes its 16x-oversample
//  level clock (clkout), recovers 8N1 frames from rxd and presents bytes to the
//  PDSVM sample loader through a holding register with valid/read handshake.
//  Sits between the board UART pin and the feature-vector buffer; all logic runs on clk50.
// PARAMETERS
//  DATA_BITS   8   data bits per frame, LSB first
//  OVERSAMPLE  16  baud16 ticks per bit period (even, >=4)
// PORTS
//  clk50      in   1          system clock, 50 MHz; all flops on posedge
//  reset      in   1          asynchronous, active-high reset
//  baud16     in   1          level clock from clkdiv; tick = rising edge (baud16 & ~baud16_q)
//  rxd        in   1          serial line, idle high; asynchronous to clk50
//  rd         in   1          one-cycle strobe: consumer has taken data
//  data       out  DATA_BITS  last received byte
//  data_valid out  1          holding register full
//  frame_err  out  1          one-cycle pulse: stop bit sampled low
//  overrun    out  1          sticky: byte completed while data_valid=1
//  busy       out  1          high in any state except IDLE
// BEHAVIOUR
//  - Reset (async, any time incl. mid-frame): state=IDLE, counters=0, data=0,
//    data_valid=0, frame_err=0, overrun=0, busy=0; sync flops=1, baud16_q=0.
//  - rxd through 2-flop synchronizer (rxd_s); all decisions use rxd_s and occur only
//    in cycles where tick=1. The input-to-rxd_s delay is 2 clk50 cycles.
//  - os_cnt: 0..OVERSAMPLE-1; bit_cnt: 0..DATA_BITS-1.
//  - IDLE: tick & rxd_s==0 -> START, os_cnt=0.
//  - START: each tick, os_cnt++. At the tick where os_cnt==OVERSAMPLE/2-1 (mid start bit):
//    rxd_s==1 -> IDLE (glitch rejected, no output); else os_cnt=0, bit_cnt=0 -> DATA.
//  - DATA: each tick, os_cnt++. At the tick where os_cnt==OVERSAMPLE-1: shift rxd_s into MSB
//    of shreg (LSB-first line order), os_cnt=0. The last bit moves to PARITY (macro on) or
//    STOP; otherwise bit_cnt++.
//  - STOP: at the tick where os_cnt==OVERSAMPLE-1:
//    rxd_s==1 -> data<=shreg, data_valid<=1, overrun<=data_valid&~rd, -> IDLE;
//    rxd_s==0 -> frame_err pulse, data unchanged -> BRK (wait line idle).
//  - BRK: tick & rxd_s==1 -> IDLE (break / stuck-low line never re-triggers a start).
//  - Output latency: data/data_valid/frame_err update on the clk50 edge following the
//    tick cycle of the stop-bit sample.
//  - Handshake: rd & data_valid clears data_valid and overrun next edge. A completed byte
//    in the same cycle as rd wins: data_valid stays 1, new data loaded, overrun not set.
//    rd while data_valid=0 has no effect.
//  - frame_err and a data_valid rising edge are never produced by the same frame.
//  - tick with no rxd activity in IDLE: no state change. No tick: all state held.
// CONFIGURATION
//  UART_RX_PARITY_EN defined: adds a PARITY state after DATA (one bit period, sampled at
//    os_cnt==OVERSAMPLE-1), even parity over the data bits. Adds output parity_err (1 bit,
//    reset 0). It is set with data_valid on a mismatch, cleared by rd, and the byte is
//    still delivered.
//  Not defined: no PARITY state, no parity_err port; frame is start+DATA_BITS+stop.
// TESTING
//  Bench drives baud16 as a 4-clk50-period square wave (tick every 4 clk). One bit = 64 clk.
//  1) Frame 0xA5 (line 0,1,0,1,0,0,1,0,1,1) -> data=0xA5, data_valid=1 one clk after the
//     stop-bit tick; frame_err=0, overrun=0.
//  2) rxd low for 3 ticks only, then high -> returns to IDLE, busy drops, no data_valid,
//     no frame_err.
//  3) Frame 0x3C with stop bit 0, line held low 40 ticks -> one frame_err pulse; data keeps
//     its old value; busy=1 until rxd high, then IDLE; the next 0x55 frame is received.
//  4) Frames 0x11 then 0x22 with no rd -> data=0x22, overrun=1. rd -> data_valid=0,
//     overrun=0. Repeat with rd coincident with the 0x22 completion -> overrun=0,
//     data_valid=1.
//  5) reset asserted mid-DATA of 0xFF -> all outputs 0 immediately (async); after release
//     the next 0x81 frame is received correctly.
//  6) UART_RX_PARITY_EN: 0x07 with parity 1 -> parity_err=0; with parity 0 -> parity_err=1,
//     data=0x07.

Source files
------------

// File: rtl/uart_rx_os16_if.sv
// rtl/uart_rx_os16_if.sv - bus bundle between the baud/line side, uart_rx_os16 and its byte consumer
// Optional parity_err member is present when UART_RX_PARITY_EN is defined.
interface uart_rx_os16_if #(
    parameter int DATA_BITS = 8
);
    logic                 baud16;
    logic                 rxd;
    logic                 rd;
    logic [DATA_BITS-1:0] data;
    logic                 data_valid;
    logic                 frame_err;
    logic                 overrun;
    logic                 busy;
`ifdef UART_RX_PARITY_EN
    logic                 parity_err;

    modport master (
        output baud16, rxd, rd,
        input  data, data_valid, frame_err, overrun, busy, parity_err
    );
    modport slave (
        input  baud16, rxd, rd,
        output data, data_valid, frame_err, overrun, busy, parity_err
    );
`else
    modport master (
        output baud16, rxd, rd,
        input  data, data_valid, frame_err, overrun, busy
    );
    modport slave (
        input  baud16, rxd, rd,
        output data, data_valid, frame_err, overrun, busy
    );
`endif
endinterface

// File: rtl/uart_rx_os16.sv
// rtl/uart_rx_os16.sv - 16x oversampling 8N1 UART receiver with holding register and valid/read handshake
// Define UART_RX_PARITY_EN to add an even-parity bit after the data bits and the parity_err output.
module uart_rx_os16 #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic           clk50,
    input  logic           reset,
    uart_rx_os16_if.slave  bus
);
    localparam int OSW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int BW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [OSW-1:0] OS_MID   = OSW'(OVERSAMPLE / 2 - 1);
    localparam logic [OSW-1:0] OS_LAST  = OSW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0]  BIT_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BRK
    } state_t;

    state_t               state;
    logic                 rxd_m;
    logic                 rxd_s;
    logic                 baud16_q;
    logic [OSW-1:0]       os_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shreg;
`ifdef UART_RX_PARITY_EN
    logic                 par_bit;
`endif
    logic                 tick;

    assign tick = bus.baud16 & ~baud16_q;

    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            state          <= S_IDLE;
            rxd_m          <= 1'b1;
            rxd_s          <= 1'b1;
            baud16_q       <= 1'b0;
            os_cnt         <= '0;
            bit_cnt        <= '0;
            shreg          <= '0;
            bus.data       <= '0;
            bus.data_valid <= 1'b0;
            bus.frame_err  <= 1'b0;
            bus.overrun    <= 1'b0;
            bus.busy       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit        <= 1'b0;
            bus.parity_err <= 1'b0;
`endif
        end else begin
            rxd_m         <= bus.rxd;
            rxd_s         <= rxd_m;
            baud16_q      <= bus.baud16;
            bus.frame_err <= 1'b0;

            if (bus.rd && bus.data_valid) begin
                bus.data_valid <= 1'b0;
                bus.overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
                bus.parity_err <= 1'b0;
`endif
            end

            // Completion assignments below come after the rd clear so a byte landing with rd wins.
            if (tick) begin
                case (state)
                    S_IDLE: begin
                        if (!rxd_s) begin
                            state    <= S_START;
                            os_cnt   <= '0;
                            bus.busy <= 1'b1;
                        end
                    end
                    S_START: begin
                        if (os_cnt == OS_MID) begin
                            os_cnt <= '0;
                            if (rxd_s) begin
                                state    <= S_IDLE;
                                bus.busy <= 1'b0;
                            end else begin
                                bit_cnt <= '0;
                                state   <= S_DATA;
                            end
                        end else begin
                            os_cnt <= os_cnt + 1'b1;
                        end
                    end
                    S_DATA: begin
                        if (os_cnt == OS_LAST) begin
                            os_cnt <= '0;
                            shreg  <= {rxd_s, shreg[DATA_BITS-1:1]};
                            if (bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                                state <= S_PARITY;
`else
                                state <= S_STOP;
`endif
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end else begin
                            os_cnt <= os_cnt + 1'b1;
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    S_PARITY: begin
                        if (os_cnt == OS_LAST) begin
                            os_cnt  <= '0;
                            par_bit <= rxd_s;
                            state   <= S_STOP;
                        end else begin
                            os_cnt <= os_cnt + 1'b1;
                        end
                    end
`endif
                    S_STOP: begin
                        if (os_cnt == OS_LAST) begin
                            os_cnt <= '0;
                            if (rxd_s) begin
                                bus.data       <= shreg;
                                bus.data_valid <= 1'b1;
                                bus.overrun    <= bus.data_valid & ~bus.rd;
`ifdef UART_RX_PARITY_EN
                                bus.parity_err <= (^shreg) ^ par_bit;
`endif
                                state          <= S_IDLE;
                                bus.busy       <= 1'b0;
                            end else begin
                                bus.frame_err <= 1'b1;
                                state         <= S_BRK;
                            end
                        end else begin
                            os_cnt <= os_cnt + 1'b1;
                        end
                    end
                    S_BRK: begin
                        if (rxd_s) begin
                            state    <= S_IDLE;
                            bus.busy <= 1'b0;
                        end
                    end
                    default: begin
                        state    <= S_IDLE;
                        bus.busy <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule
